uart_rx_hostif: RTL and testbench

- Host-side register interface that sits directly downstream of the UART receiver and consumes its FIFO read port (data, data-ready, read strobe) plus its error flags.
- Prefetches one byte into a holding register, presents data/status/control registers on the 6809-style bus, latches sticky error bits and drives an active-low interrupt.
- All flops are clocked on the negative edge of clk, the same edge the receiver uses.

---
 rtl/uart_rx_hostif_if.sv | 31 +++
 rtl/uart_rx_hostif.sv | 114 +++++++++++
 tb/tb_uart_rx_hostif.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_hostif_if.sv
// Host register bus plus the receiver FIFO read port and error levels seen by uart_rx_hostif.
// The master modport is the host/receiver side; the slave modport is the register block.
interface uart_rx_hostif_if #(
    parameter int DW = 8
) ();
    logic          cs_b;
    logic          rnw;
    logic [1:0]    addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [DW-1:0] rx_data;
    logic          rx_dor;
    logic          rx_rd;
    logic          rx_frame_error;
    logic          rx_overrun;
    logic          rx_cts;

    modport master (
        output cs_b, rnw, addr, din,
        input  dout,
        output rx_data, rx_dor, rx_frame_error, rx_overrun, rx_cts,
        input  rx_rd
    );

    modport slave (
        input  cs_b, rnw, addr, din,
        output dout,
        input  rx_data, rx_dor, rx_frame_error, rx_overrun, rx_cts,
        output rx_rd
    );
endinterface

// File: rtl/uart_rx_hostif.sv
// Receive-side host registers: prefetches one byte (2 cycles from rx_dor to FULL), sticky errors, irq.
// No stalls: the FIFO is popped only from FETCH, and host side effects fire once per chip-select assertion.
module uart_rx_hostif #(
    parameter int         DW         = 8,
    parameter logic [1:0] CTRL_RESET = 2'b00
) (
    input  logic             clk,
    input  logic             reset_b,
    uart_rx_hostif_if.slave  bus,
    output logic             irq_b
);

    typedef enum logic [1:0] {EMPTY, FETCH, FULL} state_t;

    state_t        state;
    logic [DW-1:0] hold_q;
    logic [DW-1:0] scratch_q;
    logic [1:0]    ctrl_q;
    logic          fe_q;
    logic          ov_q;
    logic          fe_d;
    logic          ov_d;
    logic          cs_q;
    logic          rx_rd_q;

    logic          acc_start;
    logic          data_rd_start;
    logic          stat_rd_start;
    logic          wr_start;
    logic          fe_rise;
    logic          ov_rise;
    logic [7:0]    status;
    logic [DW-1:0] rd_dat;

    // Side effects are keyed to the first cycle of a chip-select assertion only.
    assign acc_start     = !bus.cs_b && cs_q;
    assign data_rd_start = acc_start && bus.rnw && (bus.addr == 2'd0);
    assign stat_rd_start = acc_start && bus.rnw && (bus.addr == 2'd1);
    assign wr_start      = acc_start && !bus.rnw;
    assign fe_rise       = bus.rx_frame_error && !fe_d;
    assign ov_rise       = bus.rx_overrun && !ov_d;

    assign status    = {!irq_b, 3'b000, bus.rx_cts, ov_q, fe_q, (state == FULL)};
    assign bus.rx_rd = rx_rd_q;
    assign bus.dout  = rd_dat;

    always_comb begin
        rd_dat = '0;
        if (!bus.cs_b && bus.rnw) begin
            case (bus.addr)
                2'd0:    rd_dat = hold_q;
                2'd1:    rd_dat = DW'(status);
                2'd2:    rd_dat = DW'(ctrl_q);
                default: rd_dat = scratch_q;
            endcase
        end
    end

    // Prefetch FSM: rx_rd is a registered output that is high exactly while in FETCH.
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state   <= EMPTY;
            hold_q  <= '0;
            rx_rd_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (bus.rx_dor) begin
                        state   <= FETCH;
                        rx_rd_q <= 1'b1;
                    end
                end
                FETCH: begin
                    hold_q  <= bus.rx_data;
                    rx_rd_q <= 1'b0;
                    state   <= FULL;
                end
                FULL: begin
                    if (data_rd_start) state <= EMPTY;
                end
                default: begin
                    state   <= EMPTY;
                    rx_rd_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cs_q      <= 1'b1;
            fe_d      <= 1'b0;
            ov_d      <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            ctrl_q    <= CTRL_RESET;
            scratch_q <= '0;
            irq_b     <= 1'b1;
        end else begin
            cs_q <= bus.cs_b;
            fe_d <= bus.rx_frame_error;
            ov_d <= bus.rx_overrun;
            // A new error edge beats a clear from a concurrent status read.
            if (fe_rise)            fe_q <= 1'b1;
            else if (stat_rd_start) fe_q <= 1'b0;
            if (ov_rise)            ov_q <= 1'b1;
            else if (stat_rd_start) ov_q <= 1'b0;
            if (wr_start && (bus.addr == 2'd2)) ctrl_q    <= bus.din[1:0];
            if (wr_start && (bus.addr == 2'd3)) scratch_q <= bus.din;
            irq_b <= !((ctrl_q[0] && (state == FULL)) || (ctrl_q[1] && (fe_q || ov_q)));
        end
    end

endmodule

// File: tb/tb_uart_rx_hostif.sv
module tb_uart_rx_hostif;

    logic clk;
    logic reset_b;
    logic irq_b;
    int   checks;
    int   failures;
    int   pops;
    logic [7:0] rxq[$];

    uart_rx_hostif_if #(.DW(8)) bus ();

    uart_rx_hostif #(.DW(8), .CTRL_RESET(2'b00)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus),
        .irq_b   (irq_b)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Receiver FIFO model: pops on the falling edge while rx_rd is high, head/ready refreshed mid-cycle.
    always @(negedge clk) begin
        if (bus.rx_rd === 1'b1) begin
            pops++;
            if (rxq.size() != 0) rxq.delete(0);
        end
    end

    always @(posedge clk) begin
        #2;
        bus.rx_dor  = (rxq.size() != 0);
        bus.rx_data = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    task automatic host_read(input logic [1:0] a, output logic [7:0] d);
        @(posedge clk);
        bus.cs_b = 1'b0;
        bus.rnw  = 1'b1;
        bus.addr = a;
        #1 d = bus.dout;
        @(posedge clk);
        bus.cs_b = 1'b1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] v);
        @(posedge clk);
        bus.cs_b = 1'b0;
        bus.rnw  = 1'b0;
        bus.addr = a;
        bus.din  = v;
        @(posedge clk);
        bus.cs_b = 1'b1;
        bus.rnw  = 1'b1;
    endtask

    task automatic wait_rx_rd(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.rx_rd === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s rx_rd never asserted within 10 cycles", name);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.rx_rd !== 1'b0) begin failures++; $display("FAIL reset_rx_rd got=%b exp=0", bus.rx_rd); end
        checks++;
        if (irq_b !== 1'b1) begin failures++; $display("FAIL reset_irq_b got=%b exp=1", irq_b); end
        checks++;
        if (bus.dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        @(posedge clk);
        reset_b = 1'b1;
        host_read(2'd1, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL reset_status got=%h exp=00", d); end
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        int p0;
        @(posedge clk);
        p0 = pops;
        rxq.push_back(8'hA5);
        @(posedge clk);
        #1;
        checks++;
        if (bus.rx_rd !== 1'b1) begin failures++; $display("FAIL t1_rx_rd_high got=%b exp=1", bus.rx_rd); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.rx_rd !== 1'b0) begin failures++; $display("FAIL t1_rx_rd_low got=%b exp=0", bus.rx_rd); end
        checks++;
        if (pops - p0 != 1) begin failures++; $display("FAIL t1_pops got=%0d exp=1", pops - p0); end
        host_read(2'd1, d);
        checks++;
        if (d !== 8'h01) begin failures++; $display("FAIL t1_status_full got=%h exp=01", d); end
        host_read(2'd0, d);
        checks++;
        if (d !== 8'hA5) begin failures++; $display("FAIL t1_data got=%h exp=a5", d); end
        host_read(2'd1, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL t1_status_empty got=%h exp=00", d); end
    endtask

    task automatic test_hold_cs_low();
        logic [7:0] d;
        int p0;
        @(posedge clk);
        p0 = pops;
        rxq.push_back(8'h11);
        rxq.push_back(8'h22);
        repeat (4) @(posedge clk);
        bus.cs_b = 1'b0;
        bus.rnw  = 1'b1;
        bus.addr = 2'd0;
        #1 d = bus.dout;
        checks++;
        if (d !== 8'h11) begin failures++; $display("FAIL t2_first got=%h exp=11", d); end
        repeat (5) @(posedge clk);
        bus.cs_b = 1'b1;
        repeat (2) @(posedge clk);
        host_read(2'd0, d);
        checks++;
        if (d !== 8'h22) begin failures++; $display("FAIL t2_second got=%h exp=22", d); end
        repeat (3) @(posedge clk);
        checks++;
        if (pops - p0 != 2) begin failures++; $display("FAIL t2_pops got=%0d exp=2", pops - p0); end
    endtask

    task automatic test_rx_irq();
        logic [7:0] d;
        host_write(2'd2, 8'h01);
        @(posedge clk);
        rxq.push_back(8'h3C);
        wait_rx_rd("t3_fetch");
        @(posedge clk);
        #1;
        checks++;
        if (irq_b !== 1'b1) begin failures++; $display("FAIL t3_irq_on_full got=%b exp=1", irq_b); end
        @(posedge clk);
        #1;
        checks++;
        if (irq_b !== 1'b0) begin failures++; $display("FAIL t3_irq_asserted got=%b exp=0", irq_b); end
        host_read(2'd0, d);
        checks++;
        if (d !== 8'h3C) begin failures++; $display("FAIL t3_data got=%h exp=3c", d); end
        #1;
        checks++;
        if (irq_b !== 1'b0) begin failures++; $display("FAIL t3_irq_after_start got=%b exp=0", irq_b); end
        @(posedge clk);
        #1;
        checks++;
        if (irq_b !== 1'b1) begin failures++; $display("FAIL t3_irq_released got=%b exp=1", irq_b); end
        host_write(2'd2, 8'h00);
    endtask

    task automatic test_err_irq();
        logic [7:0] d;
        host_write(2'd2, 8'h02);
        @(posedge clk);
        bus.rx_frame_error = 1'b1;
        @(posedge clk);
        bus.rx_frame_error = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (irq_b !== 1'b0) begin failures++; $display("FAIL t4_irq_low got=%b exp=0", irq_b); end
        host_read(2'd1, d);
        checks++;
        if (d !== 8'h82) begin failures++; $display("FAIL t4_status_err got=%h exp=82", d); end
        host_read(2'd1, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL t4_status_clear got=%h exp=00", d); end
        #1;
        checks++;
        if (irq_b !== 1'b1) begin failures++; $display("FAIL t4_irq_high got=%b exp=1", irq_b); end
        host_write(2'd2, 8'h00);
    endtask

    task automatic test_set_wins();
        logic [7:0] d;
        @(posedge clk);
        bus.cs_b       = 1'b0;
        bus.rnw        = 1'b1;
        bus.addr       = 2'd1;
        bus.rx_overrun = 1'b1;
        #1 d = bus.dout;
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL t5_status_pre got=%h exp=00", d); end
        @(posedge clk);
        bus.cs_b       = 1'b1;
        bus.rx_overrun = 1'b0;
        host_read(2'd1, d);
        checks++;
        if (d !== 8'h04) begin failures++; $display("FAIL t5_ov_kept got=%h exp=04", d); end
        host_read(2'd1, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL t5_ov_cleared got=%h exp=00", d); end
    endtask

    task automatic test_regs();
        logic [7:0] d;
        @(posedge clk);
        bus.cs_b = 1'b0;
        bus.rnw  = 1'b0;
        bus.addr = 2'd3;
        bus.din  = 8'h5A;
        #1;
        checks++;
        if (bus.dout !== 8'h00) begin failures++; $display("FAIL regs_dout_on_write got=%h exp=00", bus.dout); end
        @(posedge clk);
        bus.cs_b = 1'b1;
        bus.rnw  = 1'b1;
        host_read(2'd3, d);
        checks++;
        if (d !== 8'h5A) begin failures++; $display("FAIL regs_scratch got=%h exp=5a", d); end
        host_write(2'd0, 8'hFF);
        host_read(2'd0, d);
        checks++;
        if (d !== 8'h3C) begin failures++; $display("FAIL regs_stale_hold got=%h exp=3c", d); end
        host_write(2'd2, 8'hFF);
        host_read(2'd2, d);
        checks++;
        if (d !== 8'h03) begin failures++; $display("FAIL regs_ctrl got=%h exp=03", d); end
        host_write(2'd2, 8'h00);
    endtask

    task automatic test_reset_mid_fetch();
        logic [7:0] d;
        host_write(2'd3, 8'hC3);
        host_write(2'd2, 8'h02);
        @(posedge clk);
        bus.rx_frame_error = 1'b1;
        @(posedge clk);
        bus.rx_frame_error = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (irq_b !== 1'b0) begin failures++; $display("FAIL t6_irq_before got=%b exp=0", irq_b); end
        rxq.push_back(8'h77);
        wait_rx_rd("t6_fetch");
        reset_b = 1'b0;
        #1;
        checks++;
        if (bus.rx_rd !== 1'b0) begin failures++; $display("FAIL t6_rx_rd got=%b exp=0", bus.rx_rd); end
        checks++;
        if (irq_b !== 1'b1) begin failures++; $display("FAIL t6_irq_b got=%b exp=1", irq_b); end
        checks++;
        if (bus.dout !== 8'h00) begin failures++; $display("FAIL t6_dout got=%h exp=00", bus.dout); end
        @(posedge clk);
        reset_b = 1'b1;
        host_read(2'd2, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL t6_ctrl got=%h exp=00", d); end
        host_read(2'd3, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL t6_scratch got=%h exp=00", d); end
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        pops               = 0;
        reset_b            = 1'b0;
        bus.cs_b           = 1'b1;
        bus.rnw            = 1'b1;
        bus.addr           = 2'd0;
        bus.din            = 8'h00;
        bus.rx_frame_error = 1'b0;
        bus.rx_overrun     = 1'b0;
        bus.rx_cts         = 1'b0;

        test_reset();
        test_single_byte();
        test_hold_cs_low();
        test_rx_irq();
        test_err_irq();
        test_set_wins();
        test_regs();
        test_reset_mid_fetch();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
